handshake_responder_clkb: RTL
=============================

Name: handshake_responder_clkb

Overview:
- Destination (clkB) end of a toggle-based req/ack crossing that carries a data word from clkA into clkB.
- The clkA-side sender presents a data word, holds it stable, and toggles a request.
- This block synchronizes the request, captures the word, and offers it downstream with valid/ready.
- Once downstream accepts, it toggles an acknowledge back for the sender to synchronize.

Parameters:
- DATA_W, 8, width of transferred word.
- SYNC_STAGES, 2, flops in the request synchronizer; legal values are 2 or more.

Ports:
- clkB  in  1  destination clock; the only clock in this block.
- rst_n_clkB  in  1  asynchronous, active-low reset.
- ReqToggle_async  in  1  request toggle from the clkA domain; asynchronous to clkB.
- Data_async  in  DATA_W  word from the clkA domain; stable from before a ReqToggle change until the matching AckToggle change is seen by the sender.
- DataOut_clkB  out  DATA_W  captured word.
- Valid_clkB  out  1  DataOut_clkB holds an unaccepted word.
- Ready_clkB  in  1  downstream accepts the word when Valid_clkB and Ready_clkB are high at a posedge.
- AckToggle_clkB  out  1  registered; toggles once per accepted word; the sender synchronizes it.
- Busy_clkB  out  1  high in HOLD state.

Behaviour:
- Reset is asynchronous, active-low; one clock, clkB.
- Reset values: sync chain all 0, last_q 0, DataOut_clkB 0, Valid_clkB 0, AckToggle_clkB 0, Busy_clkB 0, state IDLE.
- The sender also resets its toggle to 0. Both ends must be reset together; a mid-transfer reset of only one end is unsupported.
- Sync chain: sync_q[0] <= ReqToggle_async, then sync_q[i] <= sync_q[i-1] each posedge.
- Edge detect: req_edge = sync_q[SYNC_STAGES-1] ^ last_q (combinational).
- FSM, IDLE:
  - If req_edge: DataOut_clkB <= Data_async, last_q <= sync_q[SYNC_STAGES-1], Valid_clkB <= 1, go to HOLD.
  - Else: hold all state.
- FSM, HOLD:
  - If Ready_clkB: Valid_clkB <= 0, AckToggle_clkB <= ~AckToggle_clkB, go to IDLE.
  - Else: hold all outputs; DataOut_clkB does not change while Valid_clkB is high.
- Latency: ReqToggle_async changes before posedge 1 → Valid_clkB high after posedge SYNC_STAGES+1 (3 with the default).
- If Ready_clkB is already high, AckToggle_clkB toggles after posedge SYNC_STAGES+2.
- Back-to-back: a req_edge in IDLE on the cycle immediately after returning from HOLD is captured normally. No dead cycle beyond the single IDLE cycle.
- Protocol violation: a req_edge while in HOLD means the sender toggled without waiting for the ack.
  - last_q is not updated and the edge stays pending.
  - It is serviced on the next IDLE cycle with the Data_async sampled then.
  - Data integrity is not guaranteed in this case.
- Ready_clkB while Valid_clkB is low is ignored.
- Data_async is never synchronized bit-wise. Correctness relies on the sender's hold rule plus the SYNC_STAGES delay of the request.

Optional Feature:
- Macro: HS_OVERRUN_DETECT_EN.
- Defined:
  - Adds outputs Overrun_clkB (1 bit, sticky) and OverrunCnt_clkB (8 bits, saturating at 255), plus input OverrunClr_clkB (1 bit).
  - On each cycle in HOLD with req_edge high: Overrun_clkB <= 1 and OverrunCnt_clkB increments.
  - The same pending edge counts only once; track this with a flag cleared on leaving HOLD.
  - OverrunClr_clkB clears both outputs. If a clear and a new overrun occur in the same cycle, the clear wins.
  - Both reset to 0.
- Not defined: these ports and logic are absent; datapath behaviour is otherwise identical.

Decomposition:
- Package cdc_pkg:
  - state enum typedef hs_state_t {HS_IDLE, HS_HOLD}.
  - localparam SYNC_STAGES_MIN = 2.
  - Elaboration check: SYNC_STAGES >= SYNC_STAGES_MIN.
- Sub-module sync_chain: parameterised SYNC_STAGES-deep 1-bit synchronizer with async active-low reset to 0. Reusable for the sender's ack path.

Test Plan:
- Reset release, all inputs 0, then idle 20 cycles → Valid_clkB 0, AckToggle_clkB 0, Busy_clkB 0 throughout.
- Data_async=8'hA5, toggle ReqToggle_async 0→1, Ready_clkB held 1 → Valid_clkB high exactly after posedge 3, DataOut_clkB=8'hA5, AckToggle_clkB 0→1 after posedge 4, back to IDLE.
- Same transfer, Ready_clkB low for 5 cycles after Valid_clkB rises → DataOut_clkB and Valid_clkB stable, AckToggle_clkB unchanged until the cycle Ready_clkB rises.
- Three transfers 8'h01/8'h02/8'h03; each req toggled 1 cycle after the previous ack change; Ready_clkB=1 → three accepts in order, AckToggle_clkB ends at 1, no word lost or duplicated.
- Toggle req while in HOLD (Ready_clkB=0) → second word delivered after the first accept. With HS_OVERRUN_DETECT_EN: Overrun_clkB=1 and OverrunCnt_clkB=1; OverrunClr_clkB pulse → both return to 0.
- Assert rst_n_clkB low mid-HOLD (both ends) → all outputs return to 0 immediately, asynchronously. The next normal transfer completes with SYNC_STAGES+1 latency.

Source files
------------

// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
//   Shared types and constants for the toggle req/ack clock-domain crossing.
//   hs_state_t      : responder FSM states (idle / holding a word).
//   SYNC_STAGES_MIN : fewest synchronizer flops accepted by sync_chain.
// -----------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_HOLD = 1'b1
  } hs_state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   SYNC_STAGES-deep single-bit synchronizer. Used here for the request toggle
//   and reusable on the sender side for the acknowledge toggle.
//   Ports:
//     clk   in  destination clock
//     rst_n in  asynchronous active-low reset; every stage clears to 0
//     d     in  asynchronous input bit
//     q     out synchronized bit (last stage)
// -----------------------------------------------------------------------------
module sync_chain
  import cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/handshake_responder_clkb.sv
// -----------------------------------------------------------------------------
// handshake_responder_clkb
//   clkB end of a toggle-based req/ack crossing. The request toggle is
//   synchronized, the (sender-held) data word is captured on a detected edge
//   and offered downstream with valid/ready; each accept toggles the ack.
//   Optional build macro: HS_OVERRUN_DETECT_EN adds overrun reporting.
//   Ports:
//     clkB             in  destination clock
//     rst_n_clkB       in  asynchronous active-low reset
//     ReqToggle_async  in  request toggle from clkA
//     Data_async       in  word from clkA, held stable by the sender
//     DataOut_clkB     out captured word
//     Valid_clkB       out DataOut_clkB holds an unaccepted word
//     Ready_clkB       in  downstream accept
//     AckToggle_clkB   out toggles once per accepted word
//     Overrun_clkB     out sticky overrun flag        (HS_OVERRUN_DETECT_EN)
//     OverrunCnt_clkB  out saturating overrun count   (HS_OVERRUN_DETECT_EN)
//     OverrunClr_clkB  in  clears both overrun outputs (HS_OVERRUN_DETECT_EN)
//     Busy_clkB        out high while holding a word
// -----------------------------------------------------------------------------
module handshake_responder_clkb
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clkB,
  input  logic              rst_n_clkB,
  input  logic              ReqToggle_async,
  input  logic [DATA_W-1:0] Data_async,
  output logic [DATA_W-1:0] DataOut_clkB,
  output logic              Valid_clkB,
  input  logic              Ready_clkB,
  output logic              AckToggle_clkB,
`ifdef HS_OVERRUN_DETECT_EN
  output logic              Overrun_clkB,
  output logic [7:0]        OverrunCnt_clkB,
  input  logic              OverrunClr_clkB,
`endif
  output logic              Busy_clkB
);

  logic              req_sync;
  logic              req_edge;

  hs_state_t         state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clkB),
    .rst_n (rst_n_clkB),
    .d     (ReqToggle_async),
    .q     (req_sync)
  );

  // An edge arriving during HOLD leaves last_q untouched, so it stays
  // pending and is picked up on the next IDLE cycle.
  assign req_edge = req_sync ^ last_q;

  // State register
  always_ff @(posedge clkB or negedge rst_n_clkB) begin
    if (!rst_n_clkB) begin
      state_q <= HS_IDLE;
      last_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HS_IDLE: if (req_edge)   state_d = HS_HOLD;
      HS_HOLD: if (Ready_clkB) state_d = HS_IDLE;
      default: state_d = HS_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    last_d  = last_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    unique case (state_q)
      HS_IDLE: begin
        if (req_edge) begin
          data_d  = Data_async;
          last_d  = req_sync;
          valid_d = 1'b1;
        end
      end
      HS_HOLD: begin
        if (Ready_clkB) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
        end
      end
      default: ;
    endcase
  end

  assign DataOut_clkB   = data_q;
  assign Valid_clkB     = valid_q;
  assign AckToggle_clkB = ack_q;
  assign Busy_clkB      = (state_q == HS_HOLD);

`ifdef HS_OVERRUN_DETECT_EN
  logic       ovr_q, ovr_d;
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
  logic       ovr_seen_q, ovr_seen_d;

  always_ff @(posedge clkB or negedge rst_n_clkB) begin
    if (!rst_n_clkB) begin
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= '0;
      ovr_seen_q <= 1'b0;
    end else begin
      ovr_q      <= ovr_d;
      ovr_cnt_q  <= ovr_cnt_d;
      ovr_seen_q <= ovr_seen_d;
    end
  end

  // ovr_seen marks the pending edge as already counted so a stuck edge in a
  // long HOLD is reported once; it is released when HOLD is left.
  always_comb begin
    ovr_d      = ovr_q;
    ovr_cnt_d  = ovr_cnt_q;
    ovr_seen_d = ovr_seen_q;
    if (state_q == HS_HOLD) begin
      if (req_edge && !ovr_seen_q) begin
        ovr_d      = 1'b1;
        ovr_seen_d = 1'b1;
        if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
      if (Ready_clkB) ovr_seen_d = 1'b0;
    end
    if (OverrunClr_clkB) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end
  end

  assign Overrun_clkB    = ovr_q;
  assign OverrunCnt_clkB = ovr_cnt_q;
`endif

endmodule
